// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-memory responder.
//   state_e          - responder FSM states (IDLE, WAIT, RESP)
//   NOP_INST         - instruction returned on any errored fetch
//   DEPTH_DEFAULT    - default number of 32-bit words stored
//   LATENCY_DEFAULT  - default accept-to-response latency in cycles
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INST        = 32'h0000_0013;
  localparam int unsigned DEPTH_DEFAULT   = 64;
  localparam int unsigned LATENCY_DEFAULT = 2;

endpackage

// File: rtl/imem_array.sv
// imem_array: instruction word storage, synchronous write, combinational read.
// Ports:
//   CLK        in   clock
//   wr_en_i    in   write strobe (already qualified by the caller)
//   wr_addr_i  in   word index to write
//   wr_data_i  in   word to write
//   rd_addr_i  in   word index to read
//   rd_data_o  out  word at rd_addr_i (pre-write value in a same-edge write)
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [31:0]              wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [31:0]              rd_data_o
);

  // Contents are deliberately not reset: program images survive RST.
  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/imem_responder.sv
// imem_responder: instruction fetch responder with fixed response latency.
// Accepts one request at a time in IDLE, captures the word/error on the accept
// edge, waits LATENCY cycles, then presents the response until resp_ready.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake, req_addr = byte address (PC)
//   resp_valid/resp_ready    response handshake
//   resp_inst, resp_err      fetched word / misaligned-or-out-of-range flag
//   ld_en, ld_addr, ld_data  program-load write port (word indexed)
//   busy                     high whenever the FSM is not IDLE
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEFAULT,
  parameter int unsigned LATENCY = LATENCY_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_inst,
  output logic                     resp_err,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data,
  output logic                     busy
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : '0;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        resp_valid_q;
  logic [31:0] resp_inst_q;
  logic        resp_err_q;
  logic [31:0] cap_inst_q;
  logic        cap_err_q;

  logic [31:0] rd_data;
  logic        wr_en;
  logic        misaligned;
  logic        in_range;
  logic        dec_err;
  logic [31:0] dec_inst;

  // Loads are dropped during reset and for indices beyond the array.
  assign wr_en = ld_en & ~RST & (32'(ld_addr) < DEPTH);

  imem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .CLK       (CLK),
    .wr_en_i   (wr_en),
    .wr_addr_i (ld_addr),
    .wr_data_i (ld_data),
    .rd_addr_i (req_addr[AW+1:2]),
    .rd_data_o (rd_data)
  );

  assign misaligned = |req_addr[1:0];
  assign in_range   = {2'b00, req_addr[31:2]} < DEPTH;
  assign dec_err    = misaligned | ~in_range;
  assign dec_inst   = dec_err ? NOP_INST : rd_data;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_inst_q  <= '0;
      resp_err_q   <= 1'b0;
      cap_inst_q   <= '0;
      cap_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            // Array read is combinational, so a same-edge load is not seen.
            cap_inst_q <= dec_inst;
            cap_err_q  <= dec_err;
            if (LATENCY == 1) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_inst_q  <= dec_inst;
              resp_err_q   <= dec_err;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_inst_q  <= cap_inst_q;
            resp_err_q   <= cap_err_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_inst_q  <= '0;
            resp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_inst  = resp_inst_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: randomized self-checking bench for imem_responder.
// Two instances share the clock, reset and load port: unit 0 uses LATENCY=2,
// unit 1 uses LATENCY=1. A plain word array models the memory contents.
module tb_imem_responder;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [31:0] req_addr   [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_inst  [2];
  logic        resp_err   [2];
  logic        busy       [2];
  logic        ld_en;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data;

  int unsigned lat_cfg [2] = '{2, 1};
  logic [31:0] mem_m [DEPTH];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 CLK = ~CLK;

  imem_responder #(.DEPTH(64), .LATENCY(2)) u_dut0 (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_inst(resp_inst[0]), .resp_err(resp_err[0]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy[0])
  );

  imem_responder #(.DEPTH(64), .LATENCY(1)) u_dut1 (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_inst(resp_inst[1]), .resp_err(resp_err[1]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input int unsigned a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = 6'(a); ld_data = d;
    tick();
    ld_en = 1'b0;
    mem_m[a] = d;
  endtask

  // One cycle, optionally overwriting word w with random data on that edge.
  task automatic step_maybe_load(input bit disturb, input int unsigned w);
    logic [31:0] d;
    if (disturb && w < DEPTH) begin
      d = $urandom;
      ld_en = 1'b1; ld_addr = 6'(w); ld_data = d;
      tick();
      ld_en = 1'b0;
      mem_m[w] = d;
    end else begin
      tick();
    end
  endtask

  // {err, inst} expected for a fetch of byte address addr.
  function automatic logic [32:0] model_fetch(input logic [31:0] addr);
    if (addr[1:0] != 2'b00 || (addr >> 2) >= DEPTH) return {1'b1, NOP};
    return {1'b0, mem_m[addr >> 2]};
  endfunction

  task automatic check_idle(input int u, input string tag);
    check({tag, "/resp_valid"}, 32'(resp_valid[u]), 32'd0);
    check({tag, "/resp_inst"},  resp_inst[u], 32'd0);
    check({tag, "/resp_err"},   32'(resp_err[u]), 32'd0);
    check({tag, "/busy"},       32'(busy[u]), 32'd0);
    check({tag, "/req_ready"},  32'(req_ready[u]), 32'd1);
  endtask

  // Full transaction on unit u. same_ld puts a load on the accept edge;
  // disturb rewrites the fetched word every cycle while the request is in flight.
  task automatic fetch(input int u, input logic [31:0] addr, input int hold,
                       input bit same_ld, input int unsigned ld_a, input logic [31:0] ld_d,
                       input bit disturb, input string tag);
    logic [32:0] e;
    int          lat;
    e = model_fetch(addr);
    check({tag, "/ready_before"}, 32'(req_ready[u]), 32'd1);
    req_valid[u] = 1'b1; req_addr[u] = addr; resp_ready[u] = 1'b0;
    if (same_ld) begin
      ld_en = 1'b1; ld_addr = 6'(ld_a); ld_data = ld_d;
    end
    tick();
    req_valid[u] = 1'b0; req_addr[u] = $urandom;
    if (same_ld) begin
      ld_en = 1'b0;
      mem_m[ld_a] = ld_d;
    end
    lat = 1;
    while (!resp_valid[u] && lat < 20) begin
      check({tag, "/wait_inst"}, resp_inst[u], 32'd0);
      check({tag, "/wait_busy"}, 32'(busy[u]), 32'd1);
      step_maybe_load(disturb, addr >> 2);
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(lat_cfg[u]));
    for (int i = 0; i <= hold; i++) begin
      check({tag, "/valid"},     32'(resp_valid[u]), 32'd1);
      check({tag, "/inst"},      resp_inst[u], e[31:0]);
      check({tag, "/err"},       32'(resp_err[u]), 32'(e[32]));
      check({tag, "/req_ready"}, 32'(req_ready[u]), 32'd0);
      if (i == hold) resp_ready[u] = 1'b1;
      step_maybe_load(disturb, addr >> 2);
    end
    resp_ready[u] = 1'b0;
    check_idle(u, {tag, "/after"});
  endtask

  initial begin
    logic [31:0] a;
    int          u;
    int unsigned r;
    int unsigned w;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_addr[k] = '0; resp_ready[k] = 1'b0;
    end
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    check_idle(0, "reset0");
    check_idle(1, "reset1");

    for (int unsigned k = 0; k < DEPTH; k++) load(k, $urandom);
    load(0, 32'h0050_0093);
    load(1, 32'h00A0_0113);
    load(2, 32'h0020_81B3);
    load(3, 32'h4020_8233);

    // In-order program fetch
    for (int k = 0; k < 4; k++) fetch(0, 32'(4 * k), 0, 1'b0, 0, '0, 1'b0, "seq");
    // Back-pressure: response held for 5 cycles
    fetch(0, 32'd8, 5, 1'b0, 0, '0, 1'b0, "hold5");
    // Errors: misaligned and out of range
    fetch(0, 32'd6,   0, 1'b0, 0, '0, 1'b0, "misalign");
    fetch(0, 32'd256, 0, 1'b0, 0, '0, 1'b0, "range");
    // Load on the accept edge does not affect the captured word
    fetch(0, 32'd4, 0, 1'b1, 1, 32'hDEAD_BEEF, 1'b0, "rbw");
    check("rbw/model", mem_m[1], 32'hDEAD_BEEF);
    fetch(0, 32'd4, 0, 1'b0, 0, '0, 1'b0, "rbw_next");

    // Reset in WAIT abandons the request; load during reset is ignored
    req_valid[0] = 1'b1; req_addr[0] = 32'd0;
    tick();
    req_valid[0] = 1'b0;
    check("rst/busy_in_wait", 32'(busy[0]), 32'd1);
    RST = 1'b1; ld_en = 1'b1; ld_addr = 6'd0; ld_data = 32'hBAD0_BAD0;
    tick();
    RST = 1'b0; ld_en = 1'b0;
    check("rst/valid",     32'(resp_valid[0]), 32'd0);
    check("rst/inst",      resp_inst[0], 32'd0);
    check("rst/err",       32'(resp_err[0]), 32'd0);
    check("rst/busy",      32'(busy[0]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_idle(0, "rst_quiet");
    end
    fetch(0, 32'd0, 0, 1'b0, 0, '0, 1'b0, "rst_mem");

    // LATENCY=1 unit
    fetch(1, 32'd0, 0, 1'b0, 0, '0, 1'b0, "lat1");
    fetch(1, 32'd4, 2, 1'b0, 0, '0, 1'b0, "lat1_hold");

    // Randomized mix of fetches, loads and back-pressure
    for (int k = 0; k < 60; k++) begin
      u = int'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      w = $urandom_range(0, DEPTH - 1);
      if (r < 6)      a = 32'(w * 4);
      else if (r < 8) a = 32'(w * 4 + $urandom_range(1, 3));
      else            a = ($urandom | 32'h0000_0100) & ~32'd3;
      if ($urandom_range(0, 2) == 0) load($urandom_range(0, DEPTH - 1), $urandom);
      if ($urandom_range(0, 3) == 0)
        fetch(u, a, int'($urandom_range(0, 3)), 1'b1, w, $urandom, 1'b0, "rnd_ld");
      else
        fetch(u, a, int'($urandom_range(0, 3)), 1'b0, 0, '0, 1'($urandom_range(0, 1)), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
